// File: rtl/ghadi_multi_alarm.sv
// ghadi_multi_alarm: BCD HH:MM:SS alarm clock with NUM_ALARMS programmable slots.
// It provides snooze, automatic ring timeout and lowest-index arbitration.
// Ports:
//   Ghadi, Reset            clock and synchronous active-high reset
//   *_IN digits             BCD HH:MM used by Load_Samay and Load_Alarm
//   Load_Samay              load current time (seconds cleared, prescaler restarted)
//   Load_Alarm, Alarm_Sel,  write slot Alarm_Sel with HH:MM and enable Alarm_Chalu
//   Alarm_Chalu
//   Alarm_Band, Snooze      dismiss / snooze the active alarm
//   Alarm, Alarm_Src        registered ringing flag and the slot that caused it
//   *_OUT digits            current time, BCD
module ghadi_multi_alarm #(
  parameter int CLKS_PER_SEC = 10,
  parameter int NUM_ALARMS   = 4,
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_SEC     = 60,
  localparam int SEL_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic             Ghadi,
  input  logic             Reset,
  input  logic [1:0]       Hours_Ki_Tenth_digit_IN,
  input  logic [3:0]       Hours_Ki_Ones_digit_IN,
  input  logic [3:0]       Mins_Ki_Tenth_digit_IN,
  input  logic [3:0]       Mins_Ki_Ones_digit_IN,
  input  logic             Load_Samay,
  input  logic             Load_Alarm,
  input  logic [SEL_W-1:0] Alarm_Sel,
  input  logic             Alarm_Chalu,
  input  logic             Alarm_Band,
  input  logic             Snooze,
  output logic             Alarm,
  output logic [SEL_W-1:0] Alarm_Src,
  output logic [1:0]       Hours_Ki_Tenth_digit_OUT,
  output logic [3:0]       Hours_Ki_Ones_digit_OUT,
  output logic [3:0]       Mins_Ki_Tenth_digit_OUT,
  output logic [3:0]       Mins_Ki_Ones_digit_OUT,
  output logic [3:0]       Secs_Ki_Tenth_digit_OUT,
  output logic [3:0]       Secs_Ki_Ones_digit_OUT
);

  localparam int PRE_W   = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam int SNZ_SEC = SNOOZE_MIN * 60;
  localparam int TMR_MAX = (RING_SEC > SNZ_SEC) ? RING_SEC : SNZ_SEC;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_SEC - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);
  localparam logic [TMR_W-1:0] RING_LD  = TMR_W'(RING_SEC);
  localparam logic [TMR_W-1:0] SNZ_LD   = TMR_W'(SNZ_SEC);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ZERO = TMR_W'(0);
  localparam logic [31:0]      NUM_A_U  = 32'(NUM_ALARMS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } state_e;

  typedef struct packed {
    logic       en;
    logic [1:0] h_t;
    logic [3:0] h_o;
    logic [3:0] m_t;
    logic [3:0] m_o;
  } slot_t;

  // HH:MM digit legality: hours 00..23, minute tens 0..5, ones digits 0..9.
  function automatic logic hhmm_ok(input logic [1:0] h_t, input logic [3:0] h_o,
                                   input logic [3:0] m_t, input logic [3:0] m_o);
    logic hour_ok;
    hour_ok = (h_t < 2'd2) ? (h_o <= 4'd9) : ((h_t == 2'd2) && (h_o <= 4'd3));
    return hour_ok && (m_t <= 4'd5) && (m_o <= 4'd9);
  endfunction

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       h_t_q, h_t_d;
  logic [3:0]       h_o_q, h_o_d, m_t_q, m_t_d, m_o_q, m_o_d, s_t_q, s_t_d, s_o_q, s_o_d;
  slot_t            slot_q [NUM_ALARMS];
  slot_t            slot_d [NUM_ALARMS];
  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic             alarm_q, alarm_d;

  logic             tick_s, in_ok_s, samay_ok_s, alarm_wr_s, src_off_s, sec_edge_s, hit_s;
  logic [SEL_W-1:0] hit_idx_s;
  slot_t            new_slot_s;

  // Decode tick, input validity and the qualified load strobes.
  always_comb begin
    tick_s     = (pre_q == PRE_LAST);
    in_ok_s    = hhmm_ok(Hours_Ki_Tenth_digit_IN, Hours_Ki_Ones_digit_IN,
                         Mins_Ki_Tenth_digit_IN, Mins_Ki_Ones_digit_IN);
    samay_ok_s = Load_Samay && in_ok_s;
    alarm_wr_s = Load_Alarm && in_ok_s && (32'(Alarm_Sel) < NUM_A_U);
    src_off_s  = alarm_wr_s && !Alarm_Chalu && (Alarm_Sel == src_q);
    new_slot_s = '{en: Alarm_Chalu, h_t: Hours_Ki_Tenth_digit_IN, h_o: Hours_Ki_Ones_digit_IN,
                   m_t: Mins_Ki_Tenth_digit_IN, m_o: Mins_Ki_Ones_digit_IN};
  end

  // Prescaler and BCD time next-state; a valid load wins over the tick.
  always_comb begin
    pre_d = pre_q;
    h_t_d = h_t_q; h_o_d = h_o_q; m_t_d = m_t_q; m_o_d = m_o_q; s_t_d = s_t_q; s_o_d = s_o_q;
    if (samay_ok_s) begin
      pre_d = PRE_ZERO;
      h_t_d = Hours_Ki_Tenth_digit_IN;
      h_o_d = Hours_Ki_Ones_digit_IN;
      m_t_d = Mins_Ki_Tenth_digit_IN;
      m_o_d = Mins_Ki_Ones_digit_IN;
      s_t_d = 4'd0;
      s_o_d = 4'd0;
    end else if (tick_s) begin
      pre_d = PRE_ZERO;
      if (s_o_q != 4'd9) begin
        s_o_d = s_o_q + 4'd1;
      end else begin
        s_o_d = 4'd0;
        if (s_t_q != 4'd5) begin
          s_t_d = s_t_q + 4'd1;
        end else begin
          s_t_d = 4'd0;
          if (m_o_q != 4'd9) begin
            m_o_d = m_o_q + 4'd1;
          end else begin
            m_o_d = 4'd0;
            if (m_t_q != 4'd5) begin
              m_t_d = m_t_q + 4'd1;
            end else begin
              m_t_d = 4'd0;
              if ((h_t_q == 2'd2) && (h_o_q == 4'd3)) begin
                h_t_d = 2'd0;
                h_o_d = 4'd0;
              end else if (h_o_q == 4'd9) begin
                h_o_d = 4'd0;
                h_t_d = h_t_q + 2'd1;
              end else begin
                h_o_d = h_o_q + 4'd1;
              end
            end
          end
        end
      end
    end else begin
      pre_d = pre_q + PRE_ONE;
    end
  end

  // Slot writes and match search; descending scan so the lowest index wins.
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = {SEL_W{1'b0}};
    // Only the edge that lands on HH:MM:00 can trigger, never the cycles that follow it.
    sec_edge_s = (samay_ok_s || tick_s) && (s_t_d == 4'd0) && (s_o_d == 4'd0);
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      slot_d[i] = (alarm_wr_s && (32'(Alarm_Sel) == 32'(i))) ? new_slot_s : slot_q[i];
      if (sec_edge_s && slot_q[i].en && (slot_q[i].h_t == h_t_d) && (slot_q[i].h_o == h_o_d)
          && (slot_q[i].m_t == m_t_d) && (slot_q[i].m_o == m_o_d)) begin
        hit_s     = 1'b1;
        hit_idx_s = SEL_W'(i);
      end else begin
        hit_s     = hit_s;
        hit_idx_s = hit_idx_s;
      end
    end
  end

  // Alarm FSM: ring/snooze timers count ticks; dismiss beats snooze.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    src_d   = src_q;
    case (state_q)
      ST_IDLE: begin
        if (hit_s) begin
          state_d = ST_RINGING;
          tmr_d   = RING_LD;
          src_d   = hit_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RINGING: begin
        if (Alarm_Band || src_off_s) begin
          state_d = ST_IDLE;
        end else if (Snooze) begin
          state_d = ST_SNOOZED;
          tmr_d   = SNZ_LD;
        end else if (tick_s) begin
          if (tmr_q <= TMR_ONE) begin
            state_d = ST_IDLE;
            tmr_d   = TMR_ZERO;
          end else begin
            tmr_d = tmr_q - TMR_ONE;
          end
        end else begin
          state_d = ST_RINGING;
        end
      end
      ST_SNOOZED: begin
        if (Alarm_Band || src_off_s) begin
          state_d = ST_IDLE;
        end else if (tick_s) begin
          if (tmr_q <= TMR_ONE) begin
            state_d = ST_RINGING;
            tmr_d   = RING_LD;
          end else begin
            tmr_d = tmr_q - TMR_ONE;
          end
        end else begin
          state_d = ST_SNOOZED;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = TMR_ZERO;
      end
    endcase
    alarm_d = (state_d == ST_RINGING);
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge Ghadi) begin
    if (Reset) begin
      pre_q   <= PRE_ZERO;
      h_t_q   <= 2'd0;
      h_o_q   <= 4'd0;
      m_t_q   <= 4'd0;
      m_o_q   <= 4'd0;
      s_t_q   <= 4'd0;
      s_o_q   <= 4'd0;
      state_q <= ST_IDLE;
      tmr_q   <= TMR_ZERO;
      src_q   <= {SEL_W{1'b0}};
      alarm_q <= 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_q[i] <= slot_t'(15'd0);
      end
    end else begin
      pre_q   <= pre_d;
      h_t_q   <= h_t_d;
      h_o_q   <= h_o_d;
      m_t_q   <= m_t_d;
      m_o_q   <= m_o_d;
      s_t_q   <= s_t_d;
      s_o_q   <= s_o_d;
      state_q <= state_d;
      tmr_q   <= tmr_d;
      src_q   <= src_d;
      alarm_q <= alarm_d;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign Alarm                    = alarm_q;
  assign Alarm_Src                = src_q;
  assign Hours_Ki_Tenth_digit_OUT = h_t_q;
  assign Hours_Ki_Ones_digit_OUT  = h_o_q;
  assign Mins_Ki_Tenth_digit_OUT  = m_t_q;
  assign Mins_Ki_Ones_digit_OUT   = m_o_q;
  assign Secs_Ki_Tenth_digit_OUT  = s_t_q;
  assign Secs_Ki_Ones_digit_OUT   = s_o_q;

endmodule

// File: doc/ghadi_multi_alarm.md
Name: ghadi_multi_alarm

Overview:
Parametrised next-generation alarm clock: BCD HH:MM:SS timekeeper with an internal seconds prescaler and NUM_ALARMS independently programmable alarm slots. Adds snooze, auto ring timeout, lowest-index arbitration and input validation, none of which exist in the single-alarm clock. Drives the display digits and the Alarm output directly; sits at top level beside the display driver.

Parameters:
CLKS_PER_SEC, 10, Ghadi cycles per second (>=1).
NUM_ALARMS, 4, number of alarm slots (>=1).
SNOOZE_MIN, 5, snooze length in minutes.
RING_SEC, 60, seconds of ringing before automatic dismiss.

Ports:
Ghadi  in  1  clock; the only clock.
Reset  in  1  synchronous, active-high reset.
Hours_Ki_Tenth_digit_IN  in  2  BCD hours tens for load.
Hours_Ki_Ones_digit_IN  in  4  BCD hours ones.
Mins_Ki_Tenth_digit_IN  in  4  BCD minutes tens.
Mins_Ki_Ones_digit_IN  in  4  BCD minutes ones.
Load_Samay  in  1  load current time from the *_IN digits.
Load_Alarm  in  1  write slot Alarm_Sel from the *_IN digits.
Alarm_Sel  in  max(1,clog2(NUM_ALARMS))  slot index for Load_Alarm.
Alarm_Chalu  in  1  enable bit written with Load_Alarm.
Alarm_Band  in  1  dismiss ringing/snoozed alarm.
Snooze  in  1  snooze ringing alarm.
Alarm  out  1  ringing indicator (registered).
Alarm_Src  out  max(1,clog2(NUM_ALARMS))  slot that caused the current ring.
Hours_Ki_Tenth_digit_OUT  out  2; Hours_Ki_Ones_digit_OUT  out  4; Mins_Ki_Tenth_digit_OUT  out  4; Mins_Ki_Ones_digit_OUT  out  4; Secs_Ki_Tenth_digit_OUT  out  4; Secs_Ki_Ones_digit_OUT  out  4  current time, BCD.

Behaviour:
- Reset: time 00:00:00, prescaler 0, all slots 00:00 and disabled, state IDLE, Alarm=0, Alarm_Src=0. Reset overrides all other inputs, including mid-ring and mid-snooze.
- Prescaler counts 0..CLKS_PER_SEC-1. Tick = the cycle where the count equals CLKS_PER_SEC-1; the time advances 1 s on that edge.
- BCD wrap: secs x9->(x+1)0, 59->00 with minute carry; mins 59->00 with hour carry; 09->10, 19->20, 23->00. 23:59:59 -> 00:00:00.
- Load_Samay: validated load when HH<=23, min tens<=5, each ones digit<=9. On a valid load, HH:MM is loaded, secs=00, prescaler=0, and the load wins over the tick. An invalid load is ignored entirely.
- Load_Alarm: the same validation applies, and Alarm_Sel>=NUM_ALARMS is ignored. A valid load writes the slot time and enable=Alarm_Chalu. Simultaneous Load_Samay and Load_Alarm perform both.
- Match: on the edge where the time becomes HH:MM:00 (by tick or by Load_Samay), any enabled slot equal to HH:MM triggers. Lowest index wins. Alarm=1 and Alarm_Src=index are visible the same cycle the digits show HH:MM:00.
- FSM IDLE/RINGING/SNOOZED:
  IDLE: on match -> RINGING; ring timer=RING_SEC.
  RINGING: Alarm=1; ring timer decrements per tick. Alarm_Band -> IDLE. Snooze -> SNOOZED with snooze timer=SNOOZE_MIN*60. Ring timer reaching 0 -> IDLE. Alarm_Band has priority over Snooze.
  SNOOZED: Alarm=0; timer decrements per tick; at 0 -> RINGING with ring timer reloaded and the same Alarm_Src. Alarm_Band -> IDLE.
- New matches in RINGING/SNOOZED are ignored; Alarm_Src holds its value.
- Load_Alarm that disables the slot equal to Alarm_Src while RINGING/SNOOZED -> IDLE next cycle.
- Alarm deasserts on the edge after Alarm_Band/Snooze is sampled high. Alarm_Src retains its last value in IDLE.
- Timers are sized for max(RING_SEC, SNOOZE_MIN*60).

Test Plan:
- CLKS_PER_SEC=2. Reset, then Load_Samay 10:19 -> OUT 10:19:00. After 120 cycles -> 10:20:00. Prescaler restarts from the load edge.
- Load_Samay 23:59, then 120 cycles -> 00:00:00. Load 24:00 and 09:6A -> ignored; time keeps counting.
- Slot 0 = 10:20 enabled, time 10:19:58 -> Alarm=1 with Alarm_Src=0 in the cycle OUT shows 10:20:00. Alarm_Band pulse -> Alarm=0 next cycle and stays 0.
- SNOOZE_MIN=1, RING_SEC=60. Ring at 10:20:00, Snooze at 10:20:05 -> Alarm=0, re-asserts at 10:21:05. No input -> Alarm auto-clears at 10:22:05. Band and Snooze in the same cycle -> IDLE.
- Slots 2 and 1 both 06:30 enabled, slot 3 06:30 disabled -> ring at 06:30:00 with Alarm_Src=1. Load_Alarm slot 1 with Alarm_Chalu=0 while ringing -> Alarm=0 next cycle.
- Reset asserted during RINGING -> next cycle Alarm=0, time 00:00:00, all slots disabled. 00:00 does not ring afterwards.
